multicycle_control: RTL

- Parametrised multi-cycle successor to the single-cycle opcode decoder.
- A Moore FSM sequences each instruction over 3-5 cycles: fetch, decode, execute, memory and writeback.
- Stalls on a memory ready handshake and flags illegal opcodes.
- Counts retired instructions.
- Sits between the instruction register opcode field and the shared-memory multicycle datapath.

---
 rtl/multicycle_control.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: Moore FSM stepping each instruction through
// fetch/decode/execute/memory/writeback, with memory stalls, illegal-opcode flag and retire count.
module multicycle_control #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                branch,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemToWrite,
  output logic                IRWrite,
  output logic                MemToReg,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic [1:0]          PCSource,
  output logic                illegal,
  output logic [3:0]          state,
  output logic [CNT_W-1:0]    retired
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic                illegal_q, illegal_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                retire_s;

  // State, latched opcode, illegal flag and retire counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // Next-state sequencing; retire_s marks the final cycle of a completed instruction
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = 1'b0;
    retire_s  = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  begin
        if (mem_ready) state_d = S_DECODE;
        else           state_d = S_FETCH;
      end
      S_DECODE: begin
        op_d = opcode;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (op_q == OP_LW) state_d = S_MEMRD;
        else               state_d = S_MEMWR;
      end
      S_MEMRD:  begin
        if (mem_ready) state_d = S_MEMWB;
        else           state_d = S_MEMRD;
      end
      S_MEMWB:  begin
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      S_MEMWR:  begin
        if (mem_ready) begin
          state_d  = S_FETCH;
          retire_s = 1'b1;
        end else begin
          state_d  = S_MEMWR;
        end
      end
      S_EXEC:   state_d = S_RWB;
      S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_IDLE;
    endcase
    if (retire_s) retired_d = retired_q + CNT_W'(1'b1);
    else          retired_d = retired_q;
  end

  // Moore output decode; only FETCH's IR/PC loads wait on the memory handshake
  always_comb begin
    PCWrite    = 1'b0;
    branch     = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemToWrite = 1'b0;
    IRWrite    = 1'b0;
    MemToReg   = 1'b0;
    RegDst     = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = '0;
    PCSource   = 2'b00;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      S_MEMWR: begin
        MemToWrite = 1'b1;
        IorD       = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_W'(2'd2);
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = ALUOP_W'(2'd1);
        branch   = 1'b1;
        PCSource = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_ADDIWB: RegWrite = 1'b1;
      default: begin
        PCWrite = 1'b0;
      end
    endcase
  end

  assign illegal = illegal_q;
  assign state   = state_q;
  assign retired = retired_q;

endmodule
